// File: rtl/axi_chk_pkg.sv
// Shared definitions for the AXI4 protocol checker: error bit indices, channel
// indices and payload/tracker record templates.
`ifndef AXI_CHK_PKG_SV
`define AXI_CHK_PKG_SV

// AW/AR payload record; widths come from the instantiating module's parameters.
`define AXI_CHK_AX_T(IDW, ADW) struct packed { \
  logic [IDW-1:0] id; logic [ADW-1:0] addr; logic [7:0] len; logic [2:0] size; \
  logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot; }

// Read tracker entry: the ID and burst length of one accepted AR.
`define AXI_CHK_TRK_T(IDW) struct packed { logic [IDW-1:0] id; axi_chk_pkg::axlen_t len; }

package axi_chk_pkg;
  typedef logic [7:0] axlen_t;

  localparam int ERR_AW_STABLE = 0;
  localparam int ERR_W_STABLE  = 1;
  localparam int ERR_B_STABLE  = 2;
  localparam int ERR_AR_STABLE = 3;
  localparam int ERR_R_STABLE  = 4;
  localparam int ERR_AW_DROP   = 5;
  localparam int ERR_W_DROP    = 6;
  localparam int ERR_B_DROP    = 7;
  localparam int ERR_AR_DROP   = 8;
  localparam int ERR_R_DROP    = 9;
  localparam int ERR_WLAST     = 10;
  localparam int ERR_W_NO_AW   = 11;
  localparam int ERR_B_NO_PEND = 12;
  localparam int ERR_RLAST_RID = 13;
  localparam int ERR_R_NO_AR   = 14;
  localparam int ERR_OVF_TO    = 15;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;
  localparam int N_CH  = 5;
endpackage

`endif

// File: rtl/axi_chk_fifo.sv
// Small synchronous FIFO used as the write/read burst tracker.
// Push is accepted when full only if a pop happens in the same cycle.
module axi_chk_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         srst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (srst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (PW+1)'(1);
      else if (do_pop && !do_push) cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI4 link checker: burst tracking, response matching, stability,
// outstanding overflow and handshake timeout, reported as sticky flags.
module axi_protocol_checker
  import axi_chk_pkg::*;
#(
  parameter int AXI_DATA_W      = 8,
  parameter int AXI_ADDR_W      = 8,
  parameter int AXI_ID_W        = 8,
  parameter int AXI_USER_W      = 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int RD_IN_ORDER     = 1,
  parameter int TIMEOUT_CYC     = 1024,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  err_clr,
  input  logic                  awvalid, awready,
  input  logic [AXI_ID_W-1:0]   awid,
  input  logic [AXI_ADDR_W-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awlock,
  input  logic [3:0]            awcache,
  input  logic [2:0]            awprot,
  input  logic                  wvalid, wready, wlast,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_DATA_W/8-1:0] wstrb,
  input  logic [AXI_USER_W-1:0] wuser,
  input  logic                  bvalid, bready,
  input  logic [AXI_ID_W-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic [AXI_USER_W-1:0] buser,
  input  logic                  arvalid, arready,
  input  logic [AXI_ID_W-1:0]   arid,
  input  logic [AXI_ADDR_W-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arlock,
  input  logic [3:0]            arcache,
  input  logic [2:0]            arprot,
  input  logic                  rvalid, rready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [AXI_USER_W-1:0] ruser,
  output logic [15:0]           err_vec,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [$clog2(MAX_OUTSTANDING):0] wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING):0] rd_outstanding
);
  localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int WP_W = AXI_DATA_W + AXI_DATA_W/8 + AXI_USER_W + 1;
  localparam int BP_W = AXI_ID_W + 2 + AXI_USER_W;
  localparam int RP_W = AXI_ID_W + AXI_DATA_W + 2 + 1 + AXI_USER_W;
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  typedef `AXI_CHK_AX_T(AXI_ID_W, AXI_ADDR_W) ax_t;
  typedef `AXI_CHK_TRK_T(AXI_ID_W) trk_t;

  ax_t             aw_p, aw_q, ar_p, ar_q;
  logic [WP_W-1:0] w_p, w_q;
  logic [BP_W-1:0] b_p, b_q;
  logic [RP_W-1:0] r_p, r_q;
  logic [N_CH-1:0] vld, rdy, hs, chg, stall_q, stab, drop, to_hit;
  logic [15:0]     new_err;

  assign aw_p = {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot};
  assign ar_p = {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot};
  assign w_p  = {wlast, wdata, wstrb, wuser};
  assign b_p  = {bid, bresp, buser};
  assign r_p  = {rid, rdata, rresp, rlast, ruser};
  assign vld  = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign rdy  = {rready, arready, bready, wready, awready};
  assign hs   = vld & rdy;
  assign chg  = {r_p != r_q, ar_p != ar_q, b_p != b_q, w_p != w_q, aw_p != aw_q};
  assign stab = stall_q & vld & chg;
  assign drop = stall_q & ~vld;

  // Per-channel stall timer counts down from TIMEOUT_CYC; terminal count 1 flags once.
  if (TIMEOUT_CYC > 0) begin : g_to
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [TW-1:0] tmr;
      assign to_hit[i] = vld[i] && !rdy[i] && (tmr == TW'(1));
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                        tmr <= TW'(TIMEOUT_CYC);
        else if (srst || !(vld[i] && !rdy[i])) tmr <= TW'(TIMEOUT_CYC);
        else if (tmr != '0)                  tmr <= tmr - TW'(1);
      end
    end
  end else begin : g_no_to
    assign to_hit = '0;
  end

  // Write side: awlen FIFO, beat counter, completed-burst count awaiting B.
  logic [7:0]    wr_head, wbeat, w_len;
  logic          wr_full, wr_empty, wr_push, wr_pop;
  logic [OW-1:0] wdone_cnt;
  logic          aw_cap_full, w_bypass, w_has_head, w_at_end, w_done, aw_ovf, aw_acc, b_ok;

  assign b_ok        = hs[CH_B] && (wdone_cnt != '0);
  assign aw_cap_full = (wr_outstanding == OUT_MAX) && !b_ok;
  assign w_bypass    = wr_empty && hs[CH_AW] && hs[CH_W] && !aw_cap_full;
  assign w_has_head  = !wr_empty || w_bypass;
  assign w_len       = wr_empty ? awlen : wr_head;
  assign w_at_end    = (wbeat == w_len);
  assign w_done      = hs[CH_W] && w_has_head && (wlast || w_at_end);
  assign wr_pop      = w_done && !wr_empty;
  assign aw_ovf      = hs[CH_AW] && ((wr_full && !wr_pop) || aw_cap_full);
  assign aw_acc      = hs[CH_AW] && !aw_ovf;
  // A bypassed burst that also finishes this cycle never needs a FIFO entry.
  assign wr_push     = aw_acc && !(w_bypass && w_done);

  axi_chk_fifo #(.W(8), .DEPTH(MAX_OUTSTANDING)) u_wr_fifo (
    .aclk, .aresetn, .srst, .push(wr_push), .pop(wr_pop), .wdata(awlen),
    .rdata(wr_head), .full(wr_full), .empty(wr_empty));

  // Read side: {arid, arlen} FIFO and beat counter.
  trk_t rd_head;
  logic [7:0] rbeat;
  logic rd_full, rd_empty, r_id_ok, r_at_end, r_beat_ok, r_done, ar_ovf, rd_push;

  assign r_id_ok   = (RD_IN_ORDER == 0) || (rid == rd_head.id);
  assign r_at_end  = (rbeat == rd_head.len);
  assign r_beat_ok = hs[CH_R] && !rd_empty && r_id_ok;
  assign r_done    = r_beat_ok && (rlast || r_at_end);
  assign ar_ovf    = hs[CH_AR] && rd_full && !r_done;
  assign rd_push   = hs[CH_AR] && !ar_ovf;

  axi_chk_fifo #(.W($bits(trk_t)), .DEPTH(MAX_OUTSTANDING)) u_rd_fifo (
    .aclk, .aresetn, .srst, .push(rd_push), .pop(r_done), .wdata({arid, arlen}),
    .rdata(rd_head), .full(rd_full), .empty(rd_empty));

  always_comb begin
    new_err = '0;
    new_err[ERR_AW_STABLE] = stab[CH_AW];
    new_err[ERR_W_STABLE]  = stab[CH_W];
    new_err[ERR_B_STABLE]  = stab[CH_B];
    new_err[ERR_AR_STABLE] = stab[CH_AR];
    new_err[ERR_R_STABLE]  = stab[CH_R];
    new_err[ERR_AW_DROP]   = drop[CH_AW];
    new_err[ERR_W_DROP]    = drop[CH_W];
    new_err[ERR_B_DROP]    = drop[CH_B];
    new_err[ERR_AR_DROP]   = drop[CH_AR];
    new_err[ERR_R_DROP]    = drop[CH_R];
    new_err[ERR_WLAST]     = hs[CH_W] && w_has_head && (wlast != w_at_end);
    new_err[ERR_W_NO_AW]   = hs[CH_W] && !w_has_head;
    new_err[ERR_B_NO_PEND] = hs[CH_B] && (wdone_cnt == '0);
    new_err[ERR_RLAST_RID] = hs[CH_R] && !rd_empty && (!r_id_ok || (rlast != r_at_end));
    new_err[ERR_R_NO_AR]   = hs[CH_R] && rd_empty;
    new_err[ERR_OVF_TO]    = aw_ovf || ar_ovf || (|to_hit);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      {aw_q, ar_q, w_q, b_q, r_q} <= '0;
      stall_q <= '0; wbeat <= '0; rbeat <= '0; wdone_cnt <= '0;
      wr_outstanding <= '0; rd_outstanding <= '0;
    end else if (srst) begin
      {aw_q, ar_q, w_q, b_q, r_q} <= '0;
      stall_q <= '0; wbeat <= '0; rbeat <= '0; wdone_cnt <= '0;
      wr_outstanding <= '0; rd_outstanding <= '0;
    end else begin
      {aw_q, ar_q, w_q, b_q, r_q} <= {aw_p, ar_p, w_p, b_p, r_p};
      stall_q <= vld & ~rdy;
      if (w_done)                         wbeat <= '0;
      else if (hs[CH_W] && w_has_head)    wbeat <= wbeat + 8'd1;
      if (r_done)                         rbeat <= '0;
      else if (r_beat_ok)                 rbeat <= rbeat + 8'd1;
      wdone_cnt      <= wdone_cnt + OW'(w_done) - OW'(b_ok);
      wr_outstanding <= wr_outstanding + OW'(aw_acc) - OW'(b_ok);
      rd_outstanding <= rd_outstanding + OW'(rd_push) - OW'(r_done);
    end
  end

  // err_clr wins over a same-cycle new error: that error is dropped entirely.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_vec <= '0; err_pulse <= 1'b0; err_cnt <= '0;
    end else if (srst || err_clr) begin
      err_vec <= '0; err_pulse <= 1'b0; err_cnt <= '0;
    end else begin
      err_vec   <= err_vec | new_err;
      err_pulse <= |new_err;
      if ((|new_err) && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Self-checking bench for axi_protocol_checker: directed scenarios plus random
// legal traffic compared against a queue-based transaction model.
module tb_axi_protocol_checker;
  localparam int DW = 8, ADW = 8, IW = 8, UW = 1, MO = 8, TO = 16, CW = 16;
  localparam int OW = $clog2(MO) + 1;

  logic aclk = 1'b0, aresetn = 1'b0, srst = 1'b0, err_clr = 1'b0;
  logic awvalid, awready, awlock; logic [IW-1:0] awid; logic [ADW-1:0] awaddr;
  logic [7:0] awlen; logic [2:0] awsize, awprot; logic [1:0] awburst; logic [3:0] awcache;
  logic wvalid, wready, wlast; logic [DW-1:0] wdata; logic [DW/8-1:0] wstrb; logic [UW-1:0] wuser;
  logic bvalid, bready; logic [IW-1:0] bid; logic [1:0] bresp; logic [UW-1:0] buser;
  logic arvalid, arready, arlock; logic [IW-1:0] arid; logic [ADW-1:0] araddr;
  logic [7:0] arlen; logic [2:0] arsize, arprot; logic [1:0] arburst; logic [3:0] arcache;
  logic rvalid, rready, rlast; logic [IW-1:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp;
  logic [UW-1:0] ruser;
  logic [15:0] err_vec; logic err_pulse; logic [CW-1:0] err_cnt;
  logic [OW-1:0] wr_outstanding, rd_outstanding;

  int total = 0, bad = 0;

  axi_protocol_checker #(
    .AXI_DATA_W(DW), .AXI_ADDR_W(ADW), .AXI_ID_W(IW), .AXI_USER_W(UW),
    .MAX_OUTSTANDING(MO), .RD_IN_ORDER(1), .TIMEOUT_CYC(TO), .ERR_CNT_W(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .err_clr(err_clr),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wuser(wuser),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .ruser(ruser),
    .err_vec(err_vec), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(); @(posedge aclk); #1; endtask

  task automatic idle();
    awvalid = 0; awready = 0; awid = '0; awaddr = '0; awlen = '0; awsize = '0;
    awburst = '0; awlock = 0; awcache = '0; awprot = '0;
    wvalid = 0; wready = 0; wlast = 0; wdata = '0; wstrb = '0; wuser = '0;
    bvalid = 0; bready = 0; bid = '0; bresp = '0; buser = '0;
    arvalid = 0; arready = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0;
    arburst = '0; arlock = 0; arcache = '0; arprot = '0;
    rvalid = 0; rready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; ruser = '0;
  endtask

  task automatic clear_errs(); err_clr = 1; step(); err_clr = 0; endtask

  // Channel drivers: valid held with ready low for 'stall' cycles, then accepted.
  task automatic do_aw(input int id, input int len, input int stall);
    awvalid = 1; awready = 0; awid = IW'(id); awlen = 8'(len);
    awaddr = ADW'($urandom); awsize = 3'd0; awburst = 2'd1;
    repeat (stall) step();
    awready = 1; step(); awvalid = 0; awready = 0;
  endtask

  task automatic do_w_burst(input int len, input int stall_max);
    for (int i = 0; i <= len; i++) begin
      wvalid = 1; wready = 0; wlast = (i == len); wdata = DW'($urandom); wstrb = '1;
      repeat ($urandom_range(0, stall_max)) step();
      wready = 1; step();
    end
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic do_b(input int id, input int stall);
    bvalid = 1; bready = 0; bid = IW'(id); bresp = 2'd0;
    repeat (stall) step();
    bready = 1; step(); bvalid = 0; bready = 0;
  endtask

  task automatic do_ar(input int id, input int len, input int stall);
    arvalid = 1; arready = 0; arid = IW'(id); arlen = 8'(len);
    araddr = ADW'($urandom); arsize = 3'd0; arburst = 2'd1;
    repeat (stall) step();
    arready = 1; step(); arvalid = 0; arready = 0;
  endtask

  task automatic do_r_burst(input int id, input int len, input int stall_max);
    for (int i = 0; i <= len; i++) begin
      rvalid = 1; rready = 0; rid = IW'(id); rlast = (i == len); rdata = DW'($urandom);
      repeat ($urandom_range(0, stall_max)) step();
      rready = 1; step();
    end
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic test_reset();
    idle(); aresetn = 0; repeat (3) step();
    total++; if (err_vec !== 16'h0) begin bad++; $display("FAIL reset_err_vec got=%h exp=0", err_vec); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    total++; if (wr_outstanding !== '0 || rd_outstanding !== '0) begin
      bad++; $display("FAIL reset_outstanding got wr=%0d rd=%0d exp=0", wr_outstanding, rd_outstanding); end
    aresetn = 1; step();
  endtask

  task automatic test_write_ok();
    do_aw(1, 3, 0);
    total++; if (wr_outstanding !== OW'(1)) begin bad++; $display("FAIL wr_ok_after_aw got=%0d exp=1", wr_outstanding); end
    do_w_burst(3, 0);
    do_b(1, 0);
    total++; if (wr_outstanding !== OW'(0)) begin bad++; $display("FAIL wr_ok_after_b got=%0d exp=0", wr_outstanding); end
    total++; if (err_vec !== 16'h0 || err_cnt !== '0) begin
      bad++; $display("FAIL wr_ok_errors got vec=%h cnt=%0d exp=0/0", err_vec, err_cnt); end
  endtask

  task automatic test_wlast_early();
    clear_errs();
    do_aw(2, 3, 0);
    wvalid = 1; wready = 1; wlast = 0; wdata = 8'h11; step();
    wlast = 1; wdata = 8'h22; step();
    total++; if (err_vec !== 16'h0400) begin bad++; $display("FAIL wlast_vec got=%h exp=0400", err_vec); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL wlast_pulse got=%b exp=1", err_pulse); end
    total++; if (err_cnt !== CW'(1)) begin bad++; $display("FAIL wlast_cnt got=%0d exp=1", err_cnt); end
    wvalid = 0; wready = 0; wlast = 0; step();
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL wlast_pulse_width got=%b exp=0", err_pulse); end
    do_b(2, 0);
    total++; if (wr_outstanding !== OW'(0) || err_vec !== 16'h0400) begin
      bad++; $display("FAIL wlast_b got wr=%0d vec=%h exp=0/0400", wr_outstanding, err_vec); end
  endtask

  task automatic test_stability();
    clear_errs();
    awvalid = 1; awready = 0; awid = 8'd3; awlen = 8'd0; awaddr = 8'h10; step();
    awaddr = 8'h14; step();
    total++; if (err_vec !== 16'h0001 || err_cnt !== CW'(1)) begin
      bad++; $display("FAIL aw_stable got vec=%h cnt=%0d exp=0001/1", err_vec, err_cnt); end
    awvalid = 0; step();
    total++; if (err_vec !== 16'h0021 || err_cnt !== CW'(2)) begin
      bad++; $display("FAIL aw_drop got vec=%h cnt=%0d exp=0021/2", err_vec, err_cnt); end
    idle(); step();
  endtask

  task automatic test_rd_order();
    clear_errs();
    do_ar(2, 1, 0);
    do_ar(5, 0, 0);
    rvalid = 1; rready = 1; rid = 8'd5; rlast = 1; step();
    rvalid = 0; rready = 0; rlast = 0;
    total++; if (err_vec !== 16'h2000) begin bad++; $display("FAIL rid_order_vec got=%h exp=2000", err_vec); end
    total++; if (rd_outstanding !== OW'(2)) begin bad++; $display("FAIL rid_order_out got=%0d exp=2", rd_outstanding); end
    do_r_burst(2, 1, 1);
    total++; if (rd_outstanding !== OW'(1)) begin bad++; $display("FAIL rid_order_first got=%0d exp=1", rd_outstanding); end
    do_r_burst(5, 0, 1);
    total++; if (rd_outstanding !== OW'(0) || err_cnt !== CW'(1)) begin
      bad++; $display("FAIL rid_order_done got out=%0d cnt=%0d exp=0/1", rd_outstanding, err_cnt); end
  endtask

  task automatic test_overflow();
    int ids[9];
    clear_errs();
    for (int i = 0; i < 9; i++) begin
      ids[i] = $urandom_range(0, 255);
      do_ar(ids[i], 0, 0);
      if (i == 7) begin
        total++; if (err_vec !== 16'h0 || rd_outstanding !== OW'(8)) begin
          bad++; $display("FAIL ovf_eighth got vec=%h out=%0d exp=0/8", err_vec, rd_outstanding); end
      end
    end
    total++; if (err_vec !== 16'h8000 || rd_outstanding !== OW'(8)) begin
      bad++; $display("FAIL ovf_ninth got vec=%h out=%0d exp=8000/8", err_vec, rd_outstanding); end
    for (int i = 0; i < 8; i++) do_r_burst(ids[i], 0, 0);
    total++; if (rd_outstanding !== OW'(0) || err_vec !== 16'h8000) begin
      bad++; $display("FAIL ovf_drain got out=%0d vec=%h exp=0/8000", rd_outstanding, err_vec); end
    do_b(0, 0);
    total++; if (err_vec !== 16'h9000 || wr_outstanding !== OW'(0)) begin
      bad++; $display("FAIL b_no_pend got vec=%h wr=%0d exp=9000/0", err_vec, wr_outstanding); end
  endtask

  task automatic test_timeout();
    clear_errs();
    arvalid = 1; arready = 0; arid = 8'd7; arlen = 8'd0; araddr = 8'h40;
    repeat (TO - 1) step();
    total++; if (err_vec !== 16'h0) begin bad++; $display("FAIL to_early got=%h exp=0", err_vec); end
    step();
    total++; if (err_vec !== 16'h8000 || err_cnt !== CW'(1)) begin
      bad++; $display("FAIL to_hit got vec=%h cnt=%0d exp=8000/1", err_vec, err_cnt); end
    repeat (3) step();
    total++; if (err_cnt !== CW'(1) || err_pulse !== 1'b0) begin
      bad++; $display("FAIL to_once got cnt=%0d pulse=%b exp=1/0", err_cnt, err_pulse); end
    arready = 1; step(); arvalid = 0; arready = 0; step();
    clear_errs();
    total++; if (err_vec !== 16'h0 || err_cnt !== '0 || rd_outstanding !== OW'(1)) begin
      bad++; $display("FAIL err_clr got vec=%h cnt=%0d rd=%0d exp=0/0/1", err_vec, err_cnt, rd_outstanding); end
    do_aw(4, 3, 0);
    wvalid = 1; wready = 1; wlast = 0; step();
    wvalid = 0; bvalid = 1; bready = 0; step();
    aresetn = 0; #1;
    total++; if (err_vec !== 16'h0 || err_pulse !== 1'b0 || err_cnt !== '0 ||
                 wr_outstanding !== '0 || rd_outstanding !== '0) begin
      bad++; $display("FAIL async_reset got vec=%h p=%b cnt=%0d wr=%0d rd=%0d exp=all 0",
                      err_vec, err_pulse, err_cnt, wr_outstanding, rd_outstanding); end
    idle(); step(); aresetn = 1; step();
  endtask

  // Random legal traffic; model tracks transactions as queues, not DUT state.
  task automatic test_random();
    int wq[$]; int bq[$]; int rid_q[$]; int rlen_q[$];
    int n_wr = 0; int id, len;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0: if (n_wr < MO) begin
             id = $urandom_range(0, 255); len = $urandom_range(0, 3);
             do_aw(id, len, $urandom_range(0, 3)); wq.push_back(len); bq.push_back(id); n_wr++;
           end
        1: if (wq.size() > 0) begin len = wq.pop_front(); do_w_burst(len, 2); end
        2: if (n_wr > wq.size()) begin
             do_b(bq.pop_front(), $urandom_range(0, 3)); n_wr--;
           end
        3: if (rid_q.size() < MO) begin
             id = $urandom_range(0, 255); len = $urandom_range(0, 3);
             do_ar(id, len, $urandom_range(0, 3)); rid_q.push_back(id); rlen_q.push_back(len);
           end
        default: if (rid_q.size() > 0) begin
             id = rid_q.pop_front(); len = rlen_q.pop_front(); do_r_burst(id, len, 2);
           end
      endcase
      total++; if (wr_outstanding !== OW'(n_wr)) begin
        bad++; $display("FAIL rand_wr_out it=%0d got=%0d exp=%0d", it, wr_outstanding, n_wr); end
      total++; if (rd_outstanding !== OW'(rid_q.size())) begin
        bad++; $display("FAIL rand_rd_out it=%0d got=%0d exp=%0d", it, rd_outstanding, rid_q.size()); end
      total++; if (err_vec !== 16'h0) begin
        bad++; $display("FAIL rand_err_vec it=%0d got=%h exp=0", it, err_vec); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_ok();
    test_wlast_early();
    test_stability();
    test_rd_order();
    test_overflow();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
